// File: rtl/temp_pkg.sv
// Shared definitions for the temperature scan controller: FSM state encoding,
// default sizing and the divider width.
package temp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NUM_SENSORS_DEF = 8;
  localparam int TEMP_W_DEF      = 8;
  localparam int DIV_W           = 16;

endpackage

// File: rtl/temp_div.sv
// Sequential restoring divider, one quotient bit per clock. The first bit is
// produced on the start edge, so the result is ready DIV_W edges after start.
module temp_div
  import temp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             done
);

  logic [DIV_W-1:0] rem_q;
  logic [DIV_W-1:0] quo_q;
  logic [DIV_W-1:0] dvs_q;
  logic [3:0]       steps_q;
  logic             busy_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [2*DIV_W-1:0] div_step(input logic [DIV_W-1:0] rem,
                                                  input logic [DIV_W-1:0] quo,
                                                  input logic [DIV_W-1:0] dvs);
    logic [DIV_W:0] trial;
    logic [DIV_W:0] diff;
    trial = {rem, quo[DIV_W-1]};
    diff  = trial - {1'b0, dvs};
    if (trial >= {1'b0, dvs}) begin
      return {diff[DIV_W-1:0], quo[DIV_W-2:0], 1'b1};
    end
    return {trial[DIV_W-1:0], quo[DIV_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      steps_q <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      {rem_q, quo_q} <= div_step('0, dividend, divisor);
      dvs_q          <= divisor;
      steps_q        <= 4'(DIV_W - 1);
      busy_q         <= 1'b1;
    end else if (busy_q) begin
      if (steps_q == 4'd0) begin
        busy_q <= 1'b0;
      end else begin
        {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
        steps_q        <= steps_q - 4'd1;
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = busy_q && (steps_q == 4'd0);

endmodule

// File: rtl/temp_scan_ctrl.sv
// Scans NUM_SENSORS sensors, averages the active readings (quotient/remainder)
// with a sequential divider. Macro TEMP_SCAN_AUTO_EN selects continuous scanning.
module temp_scan_ctrl
  import temp_pkg::*;
#(
  parameter int NUM_SENSORS = NUM_SENSORS_DEF,
  parameter int TEMP_W      = TEMP_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [TEMP_W-1:0] sensor_temp_i,
  input  logic              sensor_active_i,
  output logic [3:0]        sensor_sel_o,
  output logic [DIV_W-1:0]  temp_Q_o,
  output logic [DIV_W-1:0]  temp_R_o,
  output logic [7:0]        active_sensors_nr_o,
  output logic              result_valid_o,
  output logic              busy_o
);

  state_t           state_q, state_n;
  logic [DIV_W-1:0] sum_q, sum_acc;
  logic [4:0]       cnt_q, cnt_acc;
  logic             last_sensor;
  logic             div_start;
  logic             div_done;
  logic [DIV_W-1:0] div_quo;
  logic [DIV_W-1:0] div_rem;

  // Accumulation includes the sensor sampled on the current edge, so the
  // SCAN exit decision sees the final count.
  assign sum_acc     = sum_q + (sensor_active_i ? DIV_W'(sensor_temp_i) : '0);
  assign cnt_acc     = cnt_q + 5'(sensor_active_i);
  assign last_sensor = (sensor_sel_o == 4'(NUM_SENSORS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_n = ST_SCAN;
      end
      ST_SCAN: begin
        if (last_sensor) begin
          if (cnt_acc != 5'd0) begin
            state_n   = ST_DIVIDE;
            div_start = 1'b1;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_DIVIDE: begin
        if (div_done) state_n = ST_DONE;
      end
      ST_DONE: begin
`ifdef TEMP_SCAN_AUTO_EN
        state_n = ST_SCAN;
`else
        state_n = ST_IDLE;
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q               <= '0;
      cnt_q               <= '0;
      sensor_sel_o        <= '0;
      temp_Q_o            <= '0;
      temp_R_o            <= '0;
      active_sensors_nr_o <= '0;
      result_valid_o      <= 1'b0;
    end else begin
      result_valid_o <= (state_n == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            sum_q        <= '0;
            cnt_q        <= '0;
            sensor_sel_o <= '0;
          end
        end
        ST_SCAN: begin
          sum_q <= sum_acc;
          cnt_q <= cnt_acc;
          if (!last_sensor) begin
            sensor_sel_o <= sensor_sel_o + 4'd1;
          end else if (cnt_acc == 5'd0) begin
            temp_Q_o            <= '0;
            temp_R_o            <= '0;
            active_sensors_nr_o <= '0;
          end
        end
        ST_DIVIDE: begin
          if (div_done) begin
            temp_Q_o            <= div_quo;
            temp_R_o            <= div_rem;
            active_sensors_nr_o <= 8'(cnt_q);
          end
        end
        ST_DONE: begin
`ifdef TEMP_SCAN_AUTO_EN
          sum_q        <= '0;
          cnt_q        <= '0;
          sensor_sel_o <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q != ST_IDLE);

  temp_div u_div (
    .clk       (clk_i),
    .rst       (rst_i),
    .start     (div_start),
    .dividend  (sum_acc),
    .divisor   (DIV_W'(cnt_acc)),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

endmodule

// File: tb/tb_temp_scan_ctrl.sv
// Randomized self-checking bench for temp_scan_ctrl; sensor readings are served
// from per-index tables according to sensor_sel_o.
module tb_temp_scan_ctrl;

  localparam int N  = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] temp;
  logic          act;
  logic [3:0]    sel;
  logic [15:0]   q, r;
  logic [7:0]    nr;
  logic          vld, busy;

  logic [TW-1:0] tv [16];
  logic          av [16];

  int errors = 0;
  int checks = 0;

  assign temp = tv[sel];
  assign act  = av[sel];

  always #5 clk = ~clk;

  temp_scan_ctrl #(.NUM_SENSORS(N), .TEMP_W(TW)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start),
    .sensor_temp_i       (temp),
    .sensor_active_i     (act),
    .sensor_sel_o        (sel),
    .temp_Q_o            (q),
    .temp_R_o            (r),
    .active_sensors_nr_o (nr),
    .result_valid_o      (vld),
    .busy_o              (busy)
  );

  // Average of the active readings as plain integer arithmetic.
  task automatic model(output logic [15:0] eq, output logic [15:0] er, output logic [7:0] en);
    int sum = 0;
    int c = 0;
    for (int i = 0; i < N; i++) begin
      if (av[i]) begin
        sum += int'(tv[i]);
        c++;
      end
    end
    eq = (c == 0) ? 16'd0 : 16'(sum / c);
    er = (c == 0) ? 16'd0 : 16'(sum % c);
    en = 8'(c);
  endtask

  task automatic fill(input int t, input bit a);
    for (int i = 0; i < 16; i++) begin
      tv[i] = TW'(t);
      av[i] = a;
    end
  endtask

  // Pulse start for one edge and count edges until result_valid_o is seen.
  task automatic run(output int lat, output bit sel_ok);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    sel_ok = (sel == 4'd0);
    lat    = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (n < N && sel != 4'(n)) sel_ok = 1'b0;
      if (vld) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    fill(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", vld); end
    checks++; if (q !== 16'd0) begin errors++; $display("FAIL reset_q: got %0d exp 0", q); end
    checks++; if (r !== 16'd0) begin errors++; $display("FAIL reset_r: got %0d exp 0", r); end
    checks++; if (nr !== 8'd0) begin errors++; $display("FAIL reset_nr: got %0d exp 0", nr); end
    checks++; if (sel !== 4'd0) begin errors++; $display("FAIL reset_sel: got %0d exp 0", sel); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_all_active;
    int lat;
    bit sel_ok;
    fill(22, 1'b1);
    run(lat, sel_ok);
    checks++; if (lat != N + 16) begin errors++; $display("FAIL all_latency: got %0d exp %0d", lat, N + 16); end
    checks++; if (!sel_ok) begin errors++; $display("FAIL all_sel_sequence: got bad exp 0..%0d", N - 1); end
    checks++; if (q !== 16'd22) begin errors++; $display("FAIL all_q: got %0d exp 22", q); end
    checks++; if (r !== 16'd0) begin errors++; $display("FAIL all_r: got %0d exp 0", r); end
    checks++; if (nr !== 8'd8) begin errors++; $display("FAIL all_nr: got %0d exp 8", nr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL all_busy_done: got %0b exp 1", busy); end
    @(posedge clk);
    #1;
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL all_pulse_width: got %0b exp 0", vld); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL all_back_idle: got %0b exp 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (q !== 16'd22) begin errors++; $display("FAIL all_hold_q: got %0d exp 22", q); end
  endtask

  task automatic test_sparse;
    int lat;
    bit sel_ok;
    fill(99, 1'b0);
    tv[0] = 20; av[0] = 1'b1;
    tv[3] = 21; av[3] = 1'b1;
    tv[5] = 21; av[5] = 1'b1;
    run(lat, sel_ok);
    checks++; if (lat != N + 16) begin errors++; $display("FAIL sparse_latency: got %0d exp %0d", lat, N + 16); end
    checks++; if (q !== 16'd20) begin errors++; $display("FAIL sparse_q: got %0d exp 20", q); end
    checks++; if (r !== 16'd2) begin errors++; $display("FAIL sparse_r: got %0d exp 2", r); end
    checks++; if (nr !== 8'd3) begin errors++; $display("FAIL sparse_nr: got %0d exp 3", nr); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_none;
    int lat;
    bit sel_ok;
    fill(200, 1'b0);
    run(lat, sel_ok);
    checks++; if (lat != N) begin errors++; $display("FAIL none_latency: got %0d exp %0d", lat, N); end
    checks++; if (q !== 16'd0) begin errors++; $display("FAIL none_q: got %0d exp 0", q); end
    checks++; if (r !== 16'd0) begin errors++; $display("FAIL none_r: got %0d exp 0", r); end
    checks++; if (nr !== 8'd0) begin errors++; $display("FAIL none_nr: got %0d exp 0", nr); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random;
    int lat;
    bit sel_ok;
    logic [15:0] eq, er;
    logic [7:0]  en;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) begin
        tv[i] = TW'($urandom_range(0, 255));
        av[i] = 1'($urandom_range(0, 1));
      end
      model(eq, er, en);
      run(lat, sel_ok);
      checks++; if (lat != ((en == 0) ? N : N + 16)) begin errors++; $display("FAIL rand%0d_latency: got %0d nr_exp %0d", it, lat, en); end
      checks++; if (q !== eq) begin errors++; $display("FAIL rand%0d_q: got %0d exp %0d", it, q, eq); end
      checks++; if (r !== er) begin errors++; $display("FAIL rand%0d_r: got %0d exp %0d", it, r, er); end
      checks++; if (nr !== en) begin errors++; $display("FAIL rand%0d_nr: got %0d exp %0d", it, nr, en); end
      repeat (1 + $urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  task automatic test_start_during_scan;
    int pulses = 0;
    int at = -1;
    logic [15:0] cq = '0, cr = '0;
    logic [7:0]  cn = '0;
    fill(22, 1'b1);
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n <= 45; n++) begin
      @(posedge clk);
      #1;
      if (n == 4) start = 1'b0;
      if (vld) begin
        pulses++;
        at = n;
        cq = q; cr = r; cn = nr;
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL restart_pulses: got %0d exp 1", pulses); end
    checks++; if (at != N + 16) begin errors++; $display("FAIL restart_edge: got %0d exp %0d", at, N + 16); end
    checks++; if (cq !== 16'd22 || cr !== 16'd0 || cn !== 8'd8) begin errors++; $display("FAIL restart_values: got q=%0d r=%0d nr=%0d exp 22/0/8", cq, cr, cn); end
  endtask

  task automatic test_reset_divide;
    int pulses = 0;
    fill(30, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (N + 5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstdiv_busy: got %0b exp 0", busy); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL rstdiv_valid: got %0b exp 0", vld); end
    checks++; if (q !== 16'd0 || r !== 16'd0 || nr !== 8'd0) begin errors++; $display("FAIL rstdiv_outputs: got q=%0d r=%0d nr=%0d exp 0/0/0", q, r, nr); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (vld) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstdiv_no_pulse: got %0d exp 0", pulses); end
  endtask

`ifdef TEMP_SCAN_AUTO_EN
  task automatic test_auto;
    int edges[4];
    int k = 0;
    int busy_drop = 0;
    fill(25, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 200 && k < 4; n++) begin
      @(posedge clk);
      #1;
      if (!busy) busy_drop++;
      if (vld) begin
        edges[k] = n;
        k++;
        checks++; if (q !== 16'd25 || r !== 16'd0) begin errors++; $display("FAIL auto_values: got q=%0d r=%0d exp 25/0", q, r); end
      end
    end
    checks++; if (k != 4) begin errors++; $display("FAIL auto_pulse_count: got %0d exp 4", k); end
    checks++; if (busy_drop != 0) begin errors++; $display("FAIL auto_busy: got %0d idle cycles exp 0", busy_drop); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (edges[i] - edges[i-1] != N + 17) begin errors++; $display("FAIL auto_period%0d: got %0d exp %0d", i, edges[i] - edges[i-1], N + 17); end
    end
  endtask
`endif

  initial begin
    test_reset;
`ifdef TEMP_SCAN_AUTO_EN
    test_auto;
    test_reset_divide;
`else
    test_all_active;
    test_sparse;
    test_none;
    test_random;
    test_start_during_scan;
    test_all_active;
    test_reset_divide;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/temp_scan_ctrl.md
TEMP_SCAN_CTRL -- requirements
Module: temp_scan_ctrl

Interface
REQ-001 Parameter NUM_SENSORS, default 8, number of sensors scanned per measurement (2..16).
REQ-002 Parameter TEMP_W, default 8, width of one sensor temperature reading.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  request one measurement; sampled only in IDLE.
REQ-006 sensor_temp_i  input  TEMP_W  reading of the sensor addressed by sensor_sel_o.
REQ-007 sensor_active_i  input  1  addressed sensor is present/valid this cycle.
REQ-008 sensor_sel_o  output  4  registered index of the sensor being sampled.
REQ-009 temp_Q_o  output  16  quotient sum/active count, to display stage.
REQ-010 temp_R_o  output  16  remainder sum/active count, to display stage.
REQ-011 active_sensors_nr_o  output  8  number of active sensors in last measurement.
REQ-012 result_valid_o  output  1  one-cycle pulse when Q/R/nr are updated.
REQ-013 busy_o  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, SCAN, DIVIDE, DONE; encoding from shared package.
REQ-015 IDLE -> SCAN on edge k where start_i=1; sum and count cleared, sensor_sel_o=0.
REQ-016 SCAN: edges k+1..k+NUM_SENSORS each sample one sensor (index 0 first), sensor_sel_o increments by 1 per cycle; reading added to 16-bit sum and count incremented only if sensor_active_i=1.
REQ-017 After last sensor: count>0 -> DIVIDE; count=0 -> DONE directly with temp_Q_o=0, temp_R_o=0, active_sensors_nr_o=0.
REQ-018 DIVIDE: 16-cycle restoring division of sum by count (one quotient bit per cycle); -> DONE at edge k+NUM_SENSORS+16.
REQ-019 DONE: temp_Q_o, temp_R_o, active_sensors_nr_o loaded; result_valid_o high exactly one cycle; next edge -> IDLE.
REQ-020 Outputs hold last result until next DONE; temp_R_o < active_sensors_nr_o whenever nr>0.
REQ-021 start_i while busy_o=1 ignored, not queued; start_i in DONE ignored.
REQ-022 Sum cannot overflow: NUM_SENSORS*(2^TEMP_W-1) < 2^16 for legal parameters.

Reset
REQ-023 rst_i=1 at any edge, in any state: FSM -> IDLE, all outputs 0, sum/count/divider cleared, in-flight measurement discarded, no result_valid_o pulse.

Configuration
REQ-024 Macro TEMP_SCAN_AUTO_EN: defined -> DONE returns to SCAN (not IDLE) with sum/count cleared, continuous measurement, start_i ignored, busy_o permanently 1 after first start; undefined -> single-shot per start_i as above.

Structure
REQ-025 Package temp_pkg holds FSM state typedef, NUM_SENSORS/TEMP_W defaults, divider width constant (16).
REQ-026 Sub-module temp_div: sequential 16-bit restoring divider with start/done, instantiated once.

Verification
REQ-027 All 8 sensors active at 22, start at edge 0 -> result_valid_o after edge 24, Q=22, R=0, nr=8.
REQ-028 Sensors 0,3,5 active at 20,21,21, others inactive -> Q=20, R=2, nr=3.
REQ-029 No sensor active -> result_valid_o after edge 8, Q=0, R=0, nr=0.
REQ-030 rst_i pulsed during DIVIDE -> busy_o=0, outputs 0 next cycle, no result_valid_o pulse.
REQ-031 start_i re-asserted during SCAN -> single result_valid_o pulse only, values unchanged vs REQ-027.
REQ-032 TEMP_SCAN_AUTO_EN defined, constant 25 on all sensors -> result_valid_o every 25 cycles, Q=25, R=0.
